// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: default geometry and read-mode encodings.
// Imported by the RTL and by the testbench so both agree on the encodings.
package fifo_pkg;

  localparam int DATASIZE_DEF = 8;
  localparam int ADDRSIZE_DEF = 4;

  typedef enum logic {
    FWFT_OFF = 1'b0,
    FWFT_ON  = 1'b1
  } fwft_mode_e;

  function automatic int fifo_depth(input int addrsize);
    return 1 << addrsize;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: DEPTH x DATASIZE array.
// The array is written on the clock edge and read combinationally.
module sync_fifo_mem #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);

  // NOTE: the storage array has no reset; occupancy is tracked by the pointers,
  // so stale words are never observable and the array can map onto RAM.
  logic [DATASIZE-1:0] mem [2**ADDRSIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status flags, sticky overflow/underflow,
// synchronous flush and a selectable registered-read or first-word-fall-through output.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATASIZE   = DATASIZE_DEF,
  parameter int ADDRSIZE   = ADDRSIZE_DEF,
  parameter int AFULL_LVL  = fifo_depth(ADDRSIZE) - 2,
  parameter int AEMPTY_LVL = 2,
  parameter bit FWFT       = FWFT_OFF
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic                CLR_I,
  input  logic [DATASIZE-1:0] WDATA_I,
  input  logic                WINC_I,
  output logic                WFULL_O,
  output logic                AWFULL_O,
  input  logic                RINC_I,
  output logic [DATASIZE-1:0] RDATA_O,
  output logic                REMPTY_O,
  output logic                AREMPTY_O,
  output logic [ADDRSIZE:0]   LEVEL_O,
  output logic                OVF_O,
  output logic                UDF_O
);

  localparam int DEPTH = fifo_depth(ADDRSIZE);
  localparam logic [ADDRSIZE:0] DEPTH_W  = (ADDRSIZE+1)'(DEPTH);
  localparam logic [ADDRSIZE:0] AFULL_W  = (ADDRSIZE+1)'(AFULL_LVL);
  localparam logic [ADDRSIZE:0] AEMPTY_W = (ADDRSIZE+1)'(AEMPTY_LVL);

  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH || AEMPTY_LVL < 0 || AEMPTY_LVL >= DEPTH) begin : g_param_check
    $fatal(1, "sync_fifo: AFULL_LVL/AEMPTY_LVL out of range");
  end

  logic [ADDRSIZE:0]   wptr, rptr, wptr_nxt, rptr_nxt;
  logic [ADDRSIZE:0]   level, level_nxt;
  logic                rd_accept, wr_accept, mem_we;
  logic [DATASIZE-1:0] mem_rdata;

  // Pointers carry one extra bit, so their difference is the occupancy 0..DEPTH.
  assign level     = wptr - rptr;
  assign rd_accept = RINC_I && (level != '0);
  assign wr_accept = WINC_I && ((level != DEPTH_W) || rd_accept);
  assign wptr_nxt  = wptr + (ADDRSIZE+1)'(wr_accept);
  assign rptr_nxt  = rptr + (ADDRSIZE+1)'(rd_accept);
  assign level_nxt = wptr_nxt - rptr_nxt;
  assign LEVEL_O   = level;
  assign mem_we    = wr_accept && !CLR_I && !RST_I;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      wptr <= '0;
      rptr <= '0;
    end else if (CLR_I) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr_nxt;
      rptr <= rptr_nxt;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      WFULL_O   <= 1'b0;
      AWFULL_O  <= 1'b0;
      REMPTY_O  <= 1'b1;
      AREMPTY_O <= 1'b1;
      OVF_O     <= 1'b0;
      UDF_O     <= 1'b0;
    end else if (CLR_I) begin
      WFULL_O   <= 1'b0;
      AWFULL_O  <= 1'b0;
      REMPTY_O  <= 1'b1;
      AREMPTY_O <= 1'b1;
      OVF_O     <= 1'b0;
      UDF_O     <= 1'b0;
    end else begin
      WFULL_O   <= (level_nxt == DEPTH_W);
      AWFULL_O  <= (level_nxt >= AFULL_W);
      REMPTY_O  <= (level_nxt == '0);
      AREMPTY_O <= (level_nxt <= AEMPTY_W);
      if (WINC_I && !wr_accept) OVF_O <= 1'b1;
      if (RINC_I && (level == '0)) UDF_O <= 1'b1;
    end
  end

  sync_fifo_mem #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_mem (
    .clk   (CLK_I),
    .we    (mem_we),
    .waddr (wptr[ADDRSIZE-1:0]),
    .wdata (WDATA_I),
    .raddr (rptr[ADDRSIZE-1:0]),
    .rdata (mem_rdata)
  );

  if (FWFT == FWFT_ON) begin : g_fwft
    assign RDATA_O = mem_rdata;
  end else begin : g_registered
    logic [DATASIZE-1:0] rdata_q;

    always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) rdata_q <= '0;
      else if (!CLR_I && rd_accept) rdata_q <= mem_rdata;
    end

    assign RDATA_O = rdata_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: a registered-read and a FWFT instance share
// stimulus and are compared against a queue-based reference model.
module tb_sync_fifo;
  import fifo_pkg::*;

  localparam int DW    = DATASIZE_DEF;
  localparam int AW    = ADDRSIZE_DEF;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, clr, winc, rinc;
  logic [DW-1:0] wdata;

  logic          r0_full, r0_afull, r0_empty, r0_aempty, r0_ovf, r0_udf;
  logic          r1_full, r1_afull, r1_empty, r1_aempty, r1_ovf, r1_udf;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic [AW:0]   r0_level, r1_level;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic          m_ovf, m_udf;
  logic [DW-1:0] m_rdata;

  localparam logic [10:0] RESET_STATUS = {5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  wire [10:0] st0 = {r0_level, r0_full, r0_afull, r0_empty, r0_aempty, r0_ovf, r0_udf};
  wire [10:0] st1 = {r1_level, r1_full, r1_afull, r1_empty, r1_aempty, r1_ovf, r1_udf};

  always #5 clk = ~clk;

  sync_fifo #(.DATASIZE(DW), .ADDRSIZE(AW), .FWFT(FWFT_OFF)) u_dut0 (
    .CLK_I(clk), .RST_I(rst), .CLR_I(clr), .WDATA_I(wdata), .WINC_I(winc),
    .WFULL_O(r0_full), .AWFULL_O(r0_afull), .RINC_I(rinc), .RDATA_O(r0_rdata),
    .REMPTY_O(r0_empty), .AREMPTY_O(r0_aempty), .LEVEL_O(r0_level),
    .OVF_O(r0_ovf), .UDF_O(r0_udf)
  );

  sync_fifo #(.DATASIZE(DW), .ADDRSIZE(AW), .FWFT(FWFT_ON)) u_dut1 (
    .CLK_I(clk), .RST_I(rst), .CLR_I(clr), .WDATA_I(wdata), .WINC_I(winc),
    .WFULL_O(r1_full), .AWFULL_O(r1_afull), .RINC_I(rinc), .RDATA_O(r1_rdata),
    .REMPTY_O(r1_empty), .AREMPTY_O(r1_aempty), .LEVEL_O(r1_level),
    .OVF_O(r1_ovf), .UDF_O(r1_udf)
  );

  function automatic logic [10:0] exp_status();
    int n = q.size();
    return {5'(n), (n == DEPTH), (n >= DEPTH - 2), (n == 0), (n <= 2), m_ovf, m_udf};
  endfunction

  // Applies the FIFO rules to the inputs sampled at one rising edge.
  task automatic model_step();
    bit rd_ok, wr_ok;
    if (rst) begin
      q.delete();
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_rdata = '0;
    end else if (clr) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      rd_ok = rinc && (q.size() > 0);
      wr_ok = winc && (q.size() < DEPTH || rd_ok);
      if (rinc && q.size() == 0) m_udf = 1'b1;
      if (winc && !wr_ok) m_ovf = 1'b1;
      if (rd_ok) m_rdata = q.pop_front();
      if (wr_ok) q.push_back(wdata);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    winc = 1'b0; rinc = 1'b0; clr = 1'b0;
  endtask

  task automatic do_clear();
    idle();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); wdata = '0;
    repeat (2) cycle();
    checks++;
    if (st0 !== RESET_STATUS || st1 !== RESET_STATUS) begin
      failures++;
      $display("FAIL reset_status: got %b/%b expected %b", st0, st1, RESET_STATUS);
    end
    checks++;
    if (r0_rdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_rdata: got %h expected 00", r0_rdata);
    end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 17; i++) begin
      winc = 1'b1; wdata = DW'(i);
      cycle();
      checks++;
      if (st0 !== exp_status() || st1 !== exp_status()) begin
        failures++;
        $display("FAIL fill_status[%0d]: got %b/%b expected %b", i, st0, st1, exp_status());
      end
      if (i == 13 || i == 14) begin
        checks++;
        if (r0_afull !== (i == 14)) begin
          failures++;
          $display("FAIL fill_afull[%0d]: got %b expected %b", i, r0_afull, (i == 14));
        end
      end
      if (i >= 16) begin
        checks++;
        if (r0_full !== 1'b1 || r0_level !== 5'd16 || r0_ovf !== (i == 17)) begin
          failures++;
          $display("FAIL fill_full[%0d]: full=%b level=%0d ovf=%b expected 1/16/%b",
                   i, r0_full, r0_level, r0_ovf, (i == 17));
        end
      end
    end
    idle();
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
      rinc = 1'b1;
      cycle();
      checks++;
      if (r0_rdata !== DW'(i) || st0 !== exp_status()) begin
        failures++;
        $display("FAIL drain[%0d]: rdata=%h status=%b expected %h/%b",
                 i, r0_rdata, st0, DW'(i), exp_status());
      end
      if (i < 16) begin
        checks++;
        if (r1_rdata !== DW'(i + 1)) begin
          failures++;
          $display("FAIL drain_fwft_head[%0d]: got %h expected %h", i, r1_rdata, DW'(i + 1));
        end
      end
    end
    cycle();
    checks++;
    if (r0_udf !== 1'b1 || r1_udf !== 1'b1 || r0_rdata !== 8'h10 || r0_level !== 5'd0) begin
      failures++;
      $display("FAIL drain_underflow: udf=%b/%b rdata=%h level=%0d expected 1/1/10/0",
               r0_udf, r1_udf, r0_rdata, r0_level);
    end
    idle();
  endtask

  task automatic test_fwft();
    do_clear();
    checks++;
    if (st0 !== RESET_STATUS || st1 !== RESET_STATUS) begin
      failures++;
      $display("FAIL clear_flags: got %b/%b expected %b", st0, st1, RESET_STATUS);
    end
    winc = 1'b1; wdata = 8'hA5;
    cycle();
    idle();
    checks++;
    if (r1_empty !== 1'b0 || r1_rdata !== 8'hA5) begin
      failures++;
      $display("FAIL fwft_first_word: empty=%b rdata=%h expected 0/a5", r1_empty, r1_rdata);
    end
    checks++;
    if (r0_rdata !== m_rdata) begin
      failures++;
      $display("FAIL fwft_reg_hold: got %h expected %h", r0_rdata, m_rdata);
    end
    rinc = 1'b1;
    cycle();
    idle();
    checks++;
    if (r0_rdata !== 8'hA5 || r1_empty !== 1'b1) begin
      failures++;
      $display("FAIL fwft_readout: rdata=%h empty=%b expected a5/1", r0_rdata, r1_empty);
    end
  endtask

  task automatic test_simultaneous();
    do_clear();
    for (int i = 0; i < DEPTH; i++) begin
      winc = 1'b1; wdata = DW'($urandom);
      cycle();
    end
    for (int i = 0; i < 20; i++) begin
      winc = 1'b1; rinc = 1'b1; wdata = DW'($urandom);
      cycle();
      checks++;
      if (st0 !== exp_status() || st1 !== exp_status() || r0_level !== 5'd16 || r0_ovf !== 1'b0) begin
        failures++;
        $display("FAIL simul_status[%0d]: got %b/%b expected %b", i, st0, st1, exp_status());
      end
      checks++;
      if (r0_rdata !== m_rdata || r1_rdata !== q[0]) begin
        failures++;
        $display("FAIL simul_data[%0d]: got %h/%h expected %h/%h", i, r0_rdata, r1_rdata, m_rdata, q[0]);
      end
    end
    idle();
  endtask

  task automatic test_clear();
    do_clear();
    for (int i = 0; i < 7; i++) begin
      winc = 1'b1; wdata = DW'($urandom);
      cycle();
    end
    checks++;
    if (r0_level !== 5'd7) begin
      failures++;
      $display("FAIL clear_prefill: level=%0d expected 7", r0_level);
    end
    winc = 1'b1; clr = 1'b1; wdata = 8'hEE;
    cycle();
    idle();
    checks++;
    if (st0 !== RESET_STATUS || st1 !== RESET_STATUS || st0 !== exp_status()) begin
      failures++;
      $display("FAIL clear_with_write: got %b/%b expected %b", st0, st1, RESET_STATUS);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      winc = 1'b1; wdata = DW'($urandom);
      cycle();
    end
    rinc = 1'b1; winc = 1'b0;
    cycle();
    idle();
    @(posedge clk);
    model_step();
    #3;
    rst = 1'b1;
    #1;
    model_step();
    checks++;
    if (st0 !== RESET_STATUS || st1 !== RESET_STATUS || r0_rdata !== 8'h00) begin
      failures++;
      $display("FAIL async_reset: got %b/%b rdata=%h expected %b/00", st0, st1, r0_rdata, RESET_STATUS);
    end
    cycle();
    rst = 1'b0;
    winc = 1'b1; wdata = 8'h3C;
    cycle();
    idle();
    checks++;
    if (u_dut0.u_mem.mem[0] !== 8'h3C || r0_level !== 5'd1 || r1_rdata !== 8'h3C) begin
      failures++;
      $display("FAIL reset_first_addr: mem0=%h level=%0d head=%h expected 3c/1/3c",
               u_dut0.u_mem.mem[0], r0_level, r1_rdata);
    end
  endtask

  task automatic test_random();
    int wbias;
    for (int i = 0; i < 400; i++) begin
      wbias = (i < 200) ? 3 : 1;
      winc  = ($urandom_range(3, 0) < wbias);
      rinc  = ($urandom_range(3, 0) >= wbias);
      clr   = ($urandom_range(59, 0) == 0);
      wdata = DW'($urandom);
      cycle();
      checks++;
      if (st0 !== exp_status() || st1 !== exp_status() || r0_rdata !== m_rdata) begin
        failures++;
        $display("FAIL random[%0d]: status=%b/%b rdata=%h expected %b/%h",
                 i, st0, st1, r0_rdata, exp_status(), m_rdata);
      end
      if (q.size() > 0) begin
        checks++;
        if (r1_rdata !== q[0]) begin
          failures++;
          $display("FAIL random_fwft[%0d]: got %h expected %h", i, r1_rdata, q[0]);
        end
      end
    end
    idle();
  endtask

  initial begin
    m_ovf = 1'b0; m_udf = 1'b0; m_rdata = '0;
    test_reset();
    test_fill();
    test_drain();
    test_fwft();
    test_simultaneous();
    test_clear();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
